// File: rtl/linecard_egress_port_pkg.sv
// Shared types and constants for the line card egress slice.
package linecard_egress_port_pkg;
  typedef logic [11:0] vlan_t;

  localparam logic [15:0] ETHERTYPE_8021Q = 16'h8100;
  localparam logic [6:0]  BROADCAST_DEST  = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TAG,
    ST_DISCARD
  } egress_state_t;

  // 802.1Q tag as it appears on the 32-bit TX bus, byte 0 in [7:0]; PCP/DEI zero.
  function automatic logic [31:0] tag_word(input vlan_t vid);
    return {vid[7:0], 4'h0, vid[11:8], ETHERTYPE_8021Q[7:0], ETHERTYPE_8021Q[15:8]};
  endfunction
endpackage

// File: rtl/linecard_egress_port.sv
// Egress slice: port filter, optional 802.1Q insertion and 64->32 bit narrowing.
module linecard_egress_port #(
  parameter logic [6:0] PORT_NUM       = 7'd0,
  parameter logic [6:0] BROADCAST_DEST = linecard_egress_port_pkg::BROADCAST_DEST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] port_vlan,
  input  logic        port_is_trunk,
  input  logic        axi_rx_tvalid,
  output logic        axi_rx_tready,
  input  logic [63:0] axi_rx_tdata,
  input  logic [7:0]  axi_rx_tkeep,
  input  logic        axi_rx_tlast,
  input  logic [6:0]  axi_rx_tdest,
  input  logic [11:0] axi_rx_tuser,
  output logic        axi_tx_tvalid,
  input  logic        axi_tx_tready,
  output logic [31:0] axi_tx_tdata,
  output logic [3:0]  axi_tx_tkeep,
  output logic        axi_tx_tlast,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_discarded
);
  import linecard_egress_port_pkg::*;

  egress_state_t state_q, state_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [7:0]  hold_keep_q, hold_keep_d;
  logic        hold_last_q, hold_last_d;
  logic        in_frame_q, in_frame_d;
  logic [1:0]  beat_idx_q, beat_idx_d;
  logic        insert_q, insert_d;
  vlan_t       vid_q, vid_d;
  logic [15:0] sent_q, sent_d;
  logic [15:0] disc_q, disc_d;

  logic rx_ready, ld_first, ld_cont, match;

  assign match = (axi_rx_tdest == PORT_NUM) || (axi_rx_tdest == BROADCAST_DEST);

  always_comb begin
    state_d       = state_q;
    hold_data_d   = hold_data_q;
    hold_keep_d   = hold_keep_q;
    hold_last_d   = hold_last_q;
    in_frame_d    = in_frame_q;
    beat_idx_d    = beat_idx_q;
    insert_d      = insert_q;
    vid_d         = vid_q;
    sent_d        = sent_q;
    disc_d        = disc_q;
    rx_ready      = 1'b0;
    ld_first      = 1'b0;
    ld_cont       = 1'b0;
    axi_tx_tvalid = 1'b0;
    axi_tx_tdata  = 32'h0;
    axi_tx_tkeep  = 4'h0;
    axi_tx_tlast  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rx_ready = 1'b1;
        // in_frame_q marks a frame whose next beat has not arrived yet
        if (axi_rx_tvalid) begin
          if (in_frame_q) ld_cont = 1'b1;
          else            ld_first = 1'b1;
        end
      end
      ST_DISCARD: begin
        rx_ready = 1'b1;
        if (axi_rx_tvalid && axi_rx_tlast) begin
          disc_d  = disc_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        axi_tx_tvalid = 1'b1;
        axi_tx_tdata  = hold_data_q[31:0];
        axi_tx_tkeep  = hold_keep_q[3:0];
        axi_tx_tlast  = hold_last_q && (hold_keep_q[7:4] == 4'h0);
        if (axi_tx_tready) begin
          if (axi_tx_tlast) begin
            sent_d     = sent_q + 16'd1;
            in_frame_d = 1'b0;
            state_d    = ST_IDLE;
          end else if (insert_q && beat_idx_q == 2'd1) begin
            state_d = ST_TAG;
          end else begin
            state_d = ST_HIGH;
          end
        end
      end
      ST_TAG: begin
        axi_tx_tvalid = 1'b1;
        axi_tx_tdata  = tag_word(vid_q);
        axi_tx_tkeep  = 4'hF;
        if (axi_tx_tready) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        axi_tx_tvalid = 1'b1;
        axi_tx_tdata  = hold_data_q[63:32];
        axi_tx_tkeep  = hold_keep_q[7:4];
        axi_tx_tlast  = hold_last_q;
        // refill the holding register in the same cycle the high half leaves
        rx_ready      = axi_tx_tready;
        if (axi_tx_tready) begin
          if (hold_last_q) begin
            sent_d     = sent_q + 16'd1;
            in_frame_d = 1'b0;
            state_d    = ST_IDLE;
            ld_first   = axi_rx_tvalid;
          end else if (axi_rx_tvalid) begin
            ld_cont = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ld_first) begin
      vid_d    = axi_rx_tuser;
      insert_d = match && port_is_trunk && (axi_rx_tuser != port_vlan);
      if (match) begin
        hold_data_d = axi_rx_tdata;
        hold_keep_d = axi_rx_tkeep;
        hold_last_d = axi_rx_tlast;
        beat_idx_d  = 2'd0;
        in_frame_d  = 1'b1;
        state_d     = ST_LOW;
      end else if (!axi_rx_tlast) begin
        state_d = ST_DISCARD;
      end else begin
        disc_d  = disc_q + 16'd1;
        state_d = ST_IDLE;
      end
    end

    if (ld_cont) begin
      hold_data_d = axi_rx_tdata;
      hold_keep_d = axi_rx_tkeep;
      hold_last_d = axi_rx_tlast;
      beat_idx_d  = (beat_idx_q == 2'd2) ? 2'd2 : beat_idx_q + 2'd1;
      state_d     = ST_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_data_q <= 64'h0;
      hold_keep_q <= 8'h0;
      hold_last_q <= 1'b0;
      in_frame_q  <= 1'b0;
      beat_idx_q  <= 2'd0;
      insert_q    <= 1'b0;
      vid_q       <= 12'h0;
      sent_q      <= 16'h0;
      disc_q      <= 16'h0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      hold_last_q <= hold_last_d;
      in_frame_q  <= in_frame_d;
      beat_idx_q  <= beat_idx_d;
      insert_q    <= insert_d;
      vid_q       <= vid_d;
      sent_q      <= sent_d;
      disc_q      <= disc_d;
    end
  end

  assign axi_rx_tready    = rx_ready && !rst;
  assign frames_sent      = sent_q;
  assign frames_discarded = disc_q;
endmodule

// File: tb/tb_linecard_egress_port.sv
// Scoreboard bench for linecard_egress_port: directed frames, decoupled TX monitor.
module tb_linecard_egress_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] port_vlan = 12'd69;
  logic        port_is_trunk = 1'b0;
  logic        axi_rx_tvalid = 1'b0;
  logic        axi_rx_tready;
  logic [63:0] axi_rx_tdata = 64'h0;
  logic [7:0]  axi_rx_tkeep = 8'h0;
  logic        axi_rx_tlast = 1'b0;
  logic [6:0]  axi_rx_tdest = 7'h0;
  logic [11:0] axi_rx_tuser = 12'h0;
  logic        axi_tx_tvalid;
  logic        axi_tx_tready = 1'b1;
  logic [31:0] axi_tx_tdata;
  logic [3:0]  axi_tx_tkeep;
  logic        axi_tx_tlast;
  logic [15:0] frames_sent;
  logic [15:0] frames_discarded;

  linecard_egress_port #(.PORT_NUM(7'd0), .BROADCAST_DEST(7'h7F)) dut (
    .clk(clk), .rst(rst), .port_vlan(port_vlan), .port_is_trunk(port_is_trunk),
    .axi_rx_tvalid(axi_rx_tvalid), .axi_rx_tready(axi_rx_tready),
    .axi_rx_tdata(axi_rx_tdata), .axi_rx_tkeep(axi_rx_tkeep),
    .axi_rx_tlast(axi_rx_tlast), .axi_rx_tdest(axi_rx_tdest),
    .axi_rx_tuser(axi_rx_tuser), .axi_tx_tvalid(axi_tx_tvalid),
    .axi_tx_tready(axi_tx_tready), .axi_tx_tdata(axi_tx_tdata),
    .axi_tx_tkeep(axi_tx_tkeep), .axi_tx_tlast(axi_tx_tlast),
    .frames_sent(frames_sent), .frames_discarded(frames_discarded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int exp_sent = 0;
  int exp_disc = 0;
  int tx_mode = 0;   // 0: always ready, 1: toggle, 2: follow tx_force
  logic tx_force = 1'b1;
  bit   sb_en = 1'b1;
  logic [36:0] exp_q[$];   // {data, keep, last}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (tx_mode)
      1:       axi_tx_tready = ~axi_tx_tready;
      2:       axi_tx_tready = tx_force;
      default: axi_tx_tready = 1'b1;
    endcase
  end

  // Monitor: stability while stalled, then pop-and-compare on each TX handshake.
  logic        prev_stall = 1'b0;
  logic [36:0] prev_word  = 37'h0;
  always @(negedge clk) begin
    if (rst || !sb_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("tx_stable", {26'h0, axi_tx_tvalid, axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast},
            {26'h0, 1'b1, prev_word});
      if (axi_tx_tvalid && axi_tx_tready) begin
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", {27'h0, axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast}, 64'hDEAD);
        end else begin
          chk("tx_word", {27'h0, axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast}, {27'h0, exp_q.pop_front()});
        end
      end
      prev_stall = axi_tx_tvalid && !axi_tx_tready;
      prev_word  = {axi_tx_tdata, axi_tx_tkeep, axi_tx_tlast};
    end
  end

  task automatic send_frame(input logic [6:0] dest, input logic [11:0] vid,
                            input int nbytes, input int seed, input bit gaps);
    logic [7:0]  fb [0:127];
    logic [31:0] w;
    logic [3:0]  k;
    logic [63:0] d;
    logic [7:0]  k8;
    bit match, tag;
    int nw, nb, n;
    for (int i = 0; i < 128; i++) fb[i] = (i < nbytes) ? 8'((seed + i * 3) & 8'hFF) : 8'h00;
    match = (dest == 7'd0) || (dest == 7'h7F);
    tag   = match && port_is_trunk && (vid != port_vlan) && (nbytes > 12);
    if (match) begin
      nw = (nbytes + 3) / 4;
      for (int i = 0; i < nw; i++) begin
        w = {fb[i*4+3], fb[i*4+2], fb[i*4+1], fb[i*4]};
        k = 4'h0;
        for (int j = 0; j < 4; j++) if (i*4 + j < nbytes) k[j] = 1'b1;
        exp_q.push_back({w, k, (i == nw - 1)});
        if (tag && i == 2) exp_q.push_back({vid[7:0], 4'h0, vid[11:8], 8'h00, 8'h81, 4'hF, 1'b0});
      end
      exp_sent++;
    end else begin
      exp_disc++;
    end
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        axi_rx_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int j = 0; j < 8; j++) begin
        d[j*8 +: 8] = fb[b*8 + j];
        k8[j]       = (b*8 + j < nbytes);
      end
      axi_rx_tdata  = d;
      axi_rx_tkeep  = k8;
      axi_rx_tlast  = (b == nb - 1);
      axi_rx_tdest  = dest;
      axi_rx_tuser  = vid;
      axi_rx_tvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (axi_rx_tready) break;
        @(posedge clk); #1;
        n++;
        if (n > 2000) begin
          $display("FAIL rx_accept_timeout: got no tready expected tready within 2000 cycles");
          $fatal(1, "rx stalled");
        end
      end
      @(posedge clk); #1;
    end
    axi_rx_tvalid = 1'b0;
    axi_rx_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) chk({name, "_drain_timeout"}, 64'(exp_q.size()), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_frames_sent"}, 64'(frames_sent), 64'(exp_sent));
    chk({name, "_frames_discarded"}, 64'(frames_discarded), 64'(exp_disc));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", 64'(axi_tx_tvalid), 64'h0);
    chk("reset_rx_tready", 64'(axi_rx_tready), 64'h0);
    chk("reset_tdata", 64'(axi_tx_tdata), 64'h0);
    chk("reset_counters", {32'h0, frames_sent, frames_discarded}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 64-byte access frame
    port_is_trunk = 1'b0;
    send_frame(7'd0, 12'd100, 64, 8'h10, 1'b0);
    drain("plain64");

    // 64-byte trunk frame with a foreign VLAN gets the tag at word 3
    port_is_trunk = 1'b1;
    send_frame(7'd0, 12'd100, 64, 8'h20, 1'b0);
    drain("tagged64");

    // matching VLAN stays untagged; 60-byte frame ends on a half beat
    send_frame(7'd0, 12'd69, 60, 8'h30, 1'b0);
    drain("native60");

    // foreign destination sunk, then broadcast forwarded
    send_frame(7'd5, 12'd100, 24, 8'h40, 1'b0);
    send_frame(7'h7F, 12'd100, 16, 8'h50, 1'b0);
    drain("disc_bcast");

    // single-beat foreign frame: discarded straight from IDLE
    send_frame(7'd3, 12'd1, 8, 8'h60, 1'b0);
    drain("disc_single");

    // MAC backpressure toggling, random RX gaps and back-to-back frames
    tx_mode = 1;
    send_frame(7'd0, 12'd100, 64, 8'h70, 1'b1);
    send_frame(7'h7F, 12'd100, 8, 8'h80, 1'b1);
    send_frame(7'd0, 12'd100, 12, 8'h90, 1'b0);
    send_frame(7'd0, 12'd300, 13, 8'hA0, 1'b0);
    send_frame(7'd4, 12'd100, 40, 8'hB0, 1'b1);
    send_frame(7'd0, 12'd69, 1, 8'hC0, 1'b0);
    send_frame(7'd0, 12'd2047, 33, 8'hD0, 1'b1);
    drain("toggle");
    tx_mode = 0;
    @(posedge clk); #1;

    // reset while the high half of a beat is stalled
    sb_en = 1'b0;
    tx_force = 1'b1;
    tx_mode = 2;
    @(posedge clk); #1;
    axi_rx_tdata  = 64'h1122334455667788;
    axi_rx_tkeep  = 8'hFF;
    axi_rx_tlast  = 1'b0;
    axi_rx_tdest  = 7'd0;
    axi_rx_tuser  = 12'd69;
    axi_rx_tvalid = 1'b1;
    @(posedge clk); #1;        // beat accepted from IDLE
    axi_rx_tvalid = 1'b0;
    @(posedge clk); #1;        // low word leaves
    tx_force = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_high_word", {31'h0, axi_tx_tvalid, axi_tx_tdata}, {31'h0, 1'b1, 32'h11223344});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rx_tready", 64'(axi_rx_tready), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_tvalid", 64'(axi_tx_tvalid), 64'h0);
    chk("rst_mid_counters", {32'h0, frames_sent, frames_discarded}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_force = 1'b1;
    tx_mode = 0;
    exp_q.delete();
    exp_sent = 0;
    exp_disc = 0;
    sb_en = 1'b1;
    @(posedge clk); #1;
    send_frame(7'd0, 12'd100, 64, 8'hE0, 1'b0);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
